// File: rtl/stud_fifo_writer_if.sv
// stud_fifo_writer_if: host sample handshake and receiver FIFO write handshake bundle.
interface stud_fifo_writer_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] sample_i;
  logic             sample_valid_i;
  logic             sample_ready_o;
  logic [WIDTH-1:0] fifo_o;
  logic             fifo_rdy_o;
  logic             fifo_ack_i;
  logic             fifo_full_i;
  modport master (
    input  sample_i, sample_valid_i, fifo_ack_i, fifo_full_i,
    output sample_ready_o, fifo_o, fifo_rdy_o
  );
  modport slave (
    output sample_i, sample_valid_i, fifo_ack_i, fifo_full_i,
    input  sample_ready_o, fifo_o, fifo_rdy_o
  );
endinterface

// File: rtl/stud_fifo_writer.sv
// stud_fifo_writer: 2-entry skid buffer feeding an async level/ack FIFO write handshake.
// Optional request timeout with retry enabled by defining FIFO_WRITER_TIMEOUT_EN.
module stud_fifo_writer #(
  parameter int WIDTH     = 16,
  parameter int SYNC_LEN  = 2,
  parameter int SETUP_CYC = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  stud_fifo_writer_if.master  bus,
  output logic                busy_o,
  output logic [7:0]          timeout_cnt_o
);
  typedef enum logic [1:0] {IDLE, SETUP, REQ, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic rdy_q, rdy_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic ready_q, ready_d;
  logic [SYNC_LEN-1:0] ack_sync_q, ack_sync_d, full_sync_q, full_sync_d;
  logic ack_last_q;
  logic ack_s, full_s, ack_rise, push, pop;
  assign ack_s    = ack_sync_q[SYNC_LEN-1];
  assign full_s   = full_sync_q[SYNC_LEN-1];
  assign ack_rise = ack_s && !ack_last_q;
  assign push     = bus.sample_valid_i && ready_q;
  assign bus.sample_ready_o = ready_q;
  assign bus.fifo_o         = data_q;
  assign bus.fifo_rdy_o     = rdy_q;
  assign busy_o             = (state_q != IDLE) || (occ_q != 2'd0);
`ifdef FIFO_WRITER_TIMEOUT_EN
  logic [7:0] tcnt_q, tcnt_d;
  assign timeout_cnt_o = tcnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_cnt_o  = 8'd0;
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rdy_d       = rdy_q;
    pop         = 1'b0;
`ifdef FIFO_WRITER_TIMEOUT_EN
    tcnt_d      = tcnt_q;
`endif
    ack_sync_d  = SYNC_LEN'({ack_sync_q, bus.fifo_ack_i});
    full_sync_d = SYNC_LEN'({full_sync_q, bus.fifo_full_i});
    case (state_q)
      IDLE: if (occ_q != 2'd0 && !full_s) begin
        data_d  = mem_q[rd_ptr_q];
        cnt_d   = 8'd0;
        state_d = SETUP;
      end
      SETUP: if (cnt_q == 8'(SETUP_CYC)) begin
        rdy_d   = 1'b1;
        cnt_d   = 8'd0;
        state_d = REQ;
      end else cnt_d = cnt_q + 8'd1;
      REQ: if (ack_rise) begin
        pop     = 1'b1;
        rdy_d   = 1'b0;
        cnt_d   = 8'd0;
        state_d = HOLD;
      end
`ifdef FIFO_WRITER_TIMEOUT_EN
      // abort without popping so the same head word is retried
      else if (cnt_q == 8'(TIMEOUT - 1)) begin
        rdy_d   = 1'b0;
        cnt_d   = 8'd0;
        state_d = HOLD;
        tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
      end else cnt_d = cnt_q + 8'd1;
`endif
      HOLD: if (cnt_q == 8'(SYNC_LEN)) state_d = IDLE;
            else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.sample_i;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q + 2'(push) - 2'(pop);
    ready_d  = occ_d != 2'd2;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      ready_q     <= 1'b0;
      ack_sync_q  <= '0;
      full_sync_q <= '0;
      ack_last_q  <= 1'b0;
`ifdef FIFO_WRITER_TIMEOUT_EN
      tcnt_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      ready_q     <= ready_d;
      ack_sync_q  <= ack_sync_d;
      full_sync_q <= full_sync_d;
      ack_last_q  <= ack_s;
`ifdef FIFO_WRITER_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
`endif
    end
  end
endmodule
